sw_debounce: RTL and testbench

//  Conditions a raw board switch before it drives the differential output stage (sw -> diff_p/diff_n).

---
 rtl/sw_debounce_pkg.sv | 14 +
 rtl/sw_debounce_sync.sv | 26 ++
 rtl/sw_debounce.sv | 105 ++++++++++
 tb/tb_sw_debounce.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared FSM state type and default parameter values for the switch debouncer
package sw_debounce_pkg;

    typedef enum logic {
        ST_STABLE,
        ST_SETTLING
    } state_t;

    localparam int  DEF_SYNC_STAGES   = 2;
    localparam int  DEF_STABLE_CYCLES = 1000;
    localparam int  DEF_CNT_WIDTH     = 16;
    localparam logic DEF_RESET_LEVEL  = 1'b0;

endpackage

// File: rtl/sw_debounce_sync.sv
// sw_sync: SYNC_STAGES-deep synchroniser for an asynchronous pin, synchronous reset to RESET_LEVEL
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   d        in  asynchronous input
//   q        out synchronised output (last flop of the chain)
module sw_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    always_comb chain_d = {chain_q[SYNC_STAGES-2:0], d};

    always_ff @(posedge clk)
        chain_q <= rst ? {SYNC_STAGES{RESET_LEVEL}} : chain_d;

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: synchronises and debounces a raw switch, giving a clean level plus rise/fall pulses
//   clk      in  system clock, all logic on posedge
//   rst      in  synchronous active-high reset
//   sw_raw   in  asynchronous switch pin
//   sw_out   out debounced level (toggle register when SW_DEBOUNCE_TOGGLE_EN is defined)
//   rise     out one-cycle pulse on filtered 0->1
//   fall     out one-cycle pulse on filtered 1->0
//   busy     out high while a candidate change is settling
// Build option: SW_DEBOUNCE_TOGGLE_EN makes sw_out invert on every rise (push-button mode).
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter logic RESET_LEVEL   = DEF_RESET_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 2 || (2.0 ** CNT_WIDTH) <= STABLE_CYCLES)
        $error("sw_debounce: illegal parameter combination");

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 sync;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    sw_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_raw),
        .q   (sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (state_q == ST_STABLE) begin
            if (sync != level_q) begin
                state_d = ST_SETTLING;
                cnt_d   = CNT_WIDTH'(1);
            end
        end else if (sync == level_q) begin
            state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE;
            level_d = sync;
            rise_d  = sync;
            fall_d  = ~sync;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic toggle_q, toggle_d;

    always_comb toggle_d = toggle_q ^ rise_d;

    always_ff @(posedge clk)
        toggle_q <= rst ? RESET_LEVEL : toggle_d;

    assign sw_out = toggle_q;
`else
    assign sw_out = level_q;
`endif

    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_SETTLING);

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: table-driven and directed checks of the switch debouncer
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_raw = 1'b1;
    logic sw_out, rise, fall, busy;
    logic diff_p, diff_n;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sw_debounce #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .CNT_WIDTH     (16),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (sw_raw),
        .sw_out (sw_out),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    assign diff_p = sw_out;
    assign diff_n = ~sw_out;

    typedef struct {
        logic rst;
        logic sw;
        logic out_f;
        logic out_t;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic r, logic s, logic of, logic ot, logic ri, logic fa, logic b);
        vec_t v;
        v.rst = r; v.sw = s; v.out_f = of; v.out_t = ot; v.rise = ri; v.fall = fa; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nr, nf;
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 1);
        vecs[5]  = mk(0, 1, 0, 0, 0, 0, 1);
        vecs[6]  = mk(0, 1, 0, 0, 0, 0, 1);
        vecs[7]  = mk(0, 1, 1, 1, 1, 0, 0);
        vecs[8]  = mk(0, 1, 1, 1, 0, 0, 0);
        vecs[9]  = mk(0, 1, 1, 1, 0, 0, 0);
        vecs[10] = mk(0, 0, 1, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 1, 0, 0, 0);
        vecs[12] = mk(0, 0, 1, 1, 0, 0, 1);
        vecs[13] = mk(0, 0, 1, 1, 0, 0, 1);
        vecs[14] = mk(0, 0, 1, 1, 0, 0, 1);
        vecs[15] = mk(0, 0, 0, 1, 0, 1, 0);
        vecs[16] = mk(0, 0, 0, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            rst    = vecs[i].rst;
            sw_raw = vecs[i].sw;
            step();
            chk($sformatf("vec%0d sw_out", i), sw_out, TOG ? vecs[i].out_t : vecs[i].out_f);
            chk($sformatf("vec%0d rise", i), rise, vecs[i].rise);
            chk($sformatf("vec%0d fall", i), fall, vecs[i].fall);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
        end

        // second press/release: toggle mode returns to 0, follow mode tracks the switch
        nr = 0; nf = 0;
        sw_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            nr += int'(rise);
            nf += int'(fall);
        end
        chk("press2 sw_out", sw_out, TOG ? 1'b0 : 1'b1);
        chk("press2 one rise", nr == 1, 1'b1);
        chk("press2 no fall", nf == 0, 1'b1);
        chk("press2 diff_p", diff_p, TOG ? 1'b0 : 1'b1);
        chk("press2 diff_n", diff_n, TOG ? 1'b1 : 1'b0);
        nr = 0; nf = 0;
        sw_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            nr += int'(rise);
            nf += int'(fall);
        end
        chk("release2 sw_out", sw_out, 1'b0);
        chk("release2 no rise", nr == 0, 1'b1);
        chk("release2 one fall", nf == 1, 1'b1);
        chk("release2 diff_p", diff_p, 1'b0);
        chk("release2 diff_n", diff_n, 1'b1);

        // bounce: 1,1,0 repeated never stays high long enough to commit
        nr = 0; nf = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 3; j++) begin
                sw_raw = (j < 2);
                step();
                nr += int'(rise);
                nf += int'(fall);
                chk("bounce sw_out", sw_out, 1'b0);
            end
        end
        sw_raw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            nr += int'(rise);
            nf += int'(fall);
        end
        chk("bounce no rise", nr == 0, 1'b1);
        chk("bounce no fall", nf == 0, 1'b1);
        chk("bounce idle", busy, 1'b0);

        // reset while settling at cnt==2 abandons the change
        sw_raw = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("midrst busy before", busy, 1'b1);
        rst = 1'b1;
        sw_raw = 1'b0;
        step();
        chk("midrst busy", busy, 1'b0);
        chk("midrst sw_out", sw_out, 1'b0);
        chk("midrst rise", rise, 1'b0);
        rst = 1'b0;
        nr = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            nr += int'(rise) + int'(fall);
            chk("postrst sw_out", sw_out, 1'b0);
        end
        chk("postrst no pulse", nr == 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
